// File: rtl/load_streamer_if.sv
// Bundle of the load request, input word stream and the two memory write
// ports of load_streamer. The streamer sits on the slave side; whoever
// issues loads, feeds words and receives the writes uses the master side.
interface load_streamer_if #(
    parameter int DATA_WIDTH            = 8,
    parameter int length                = 16,
    parameter int NIT_neighbor          = 32,
    parameter int NIT_point_index       = 10,
    parameter int global_buf_addr_width = 17,
    parameter int NIT_addr_width        = 12,
    parameter int WORD_WIDTH            = 32
);
    logic                                          start;
    logic [global_buf_addr_width-1:0]              GB_BASE_ADDR;
    logic [global_buf_addr_width-1:0]              GB_LINES;
    logic [NIT_addr_width:0]                       NIT_ENTRIES;
    logic                                          s_valid;
    logic [WORD_WIDTH-1:0]                         s_data;
    logic                                          s_ready;
    logic                                          gb_write;
    logic [global_buf_addr_width-1:0]              gb_waddr;
    logic [DATA_WIDTH*length-1:0]                  gb_data;
    logic                                          nit_write;
    logic [NIT_addr_width-1:0]                     nit_addr;
    logic [(NIT_neighbor+1)*NIT_point_index-1:0]   nit_data;
    logic                                          load_data;
    logic                                          load_done;

    modport slave (
        input  start, GB_BASE_ADDR, GB_LINES, NIT_ENTRIES, s_valid, s_data,
        output s_ready, gb_write, gb_waddr, gb_data, nit_write, nit_addr,
               nit_data, load_data, load_done
    );

    modport master (
        output start, GB_BASE_ADDR, GB_LINES, NIT_ENTRIES, s_valid, s_data,
        input  s_ready, gb_write, gb_waddr, gb_data, nit_write, nit_addr,
               nit_data, load_data, load_done
    );
endinterface

// File: rtl/load_streamer.sv
// Load streamer: packs a stream of 32-bit words first into 128-bit global
// buffer lines and then into 330-bit neighbour-index-table entries, issuing
// one write strobe per completed line/entry. One word per cycle, no bubbles
// between lines, entries or the two phases. All outputs are registered.
module load_streamer #(
    parameter int DATA_WIDTH            = 8,
    parameter int length                = 16,
    parameter int NIT_neighbor          = 32,
    parameter int NIT_point_index       = 10,
    parameter int global_buf_addr_width = 17,
    parameter int NIT_addr_width        = 12,
    parameter int WORD_WIDTH            = 32
) (
    input  logic             clk,
    input  logic             rstn,   // active-high despite the name
    load_streamer_if.slave   bus
);
    localparam int LINE_W    = DATA_WIDTH * length;
    localparam int NIT_W     = (NIT_neighbor + 1) * NIT_point_index;
    localparam int GB_WORDS  = LINE_W / WORD_WIDTH;
    localparam int NIT_WORDS = (NIT_W + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int NIT_BUF_W = NIT_WORDS * WORD_WIDTH;
    localparam int MAX_WORDS = (NIT_WORDS > GB_WORDS) ? NIT_WORDS : GB_WORDS;
    localparam int WCNT_W    = $clog2(MAX_WORDS);
    localparam int AW        = global_buf_addr_width;
    localparam int NW        = NIT_addr_width;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GB   = 2'd1;
    localparam logic [1:0] S_NIT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state_q,     state_d;
    logic [WCNT_W-1:0]    wcnt_q,      wcnt_d;
    logic [AW-1:0]        line_idx_q,  line_idx_d;
    logic [NW:0]          entry_idx_q, entry_idx_d;
    logic [AW-1:0]        base_q,      base_d;
    logic [AW-1:0]        lines_q,     lines_d;
    logic [NW:0]          entries_q,   entries_d;
    logic [LINE_W-1:0]    gb_buf_q,    gb_buf_d;
    logic [NIT_BUF_W-1:0] nit_buf_q,   nit_buf_d;
    logic                 gb_write_q,  gb_write_d;
    logic [AW-1:0]        gb_waddr_q,  gb_waddr_d;
    logic [LINE_W-1:0]    gb_data_q,   gb_data_d;
    logic                 nit_write_q, nit_write_d;
    logic [NW-1:0]        nit_addr_q,  nit_addr_d;
    logic [NIT_W-1:0]     nit_data_q,  nit_data_d;
    logic                 s_ready_q,   s_ready_d;
    logic                 load_data_q, load_data_d;
    logic                 load_done_q, load_done_d;
    logic                 accept_s;

    assign accept_s = bus.s_valid & s_ready_q;

    // Next-state, counter and packing logic for the whole load sequence.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        line_idx_d  = line_idx_q;
        entry_idx_d = entry_idx_q;
        base_d      = base_q;
        lines_d     = lines_q;
        entries_d   = entries_q;
        gb_buf_d    = gb_buf_q;
        nit_buf_d   = nit_buf_q;
        gb_write_d  = 1'b0;
        gb_waddr_d  = gb_waddr_q;
        gb_data_d   = gb_data_q;
        nit_write_d = 1'b0;
        nit_addr_d  = nit_addr_q;
        nit_data_d  = nit_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Request parameters are latched here; later input changes are ignored.
                    base_d      = bus.GB_BASE_ADDR;
                    lines_d     = bus.GB_LINES;
                    entries_d   = bus.NIT_ENTRIES;
                    wcnt_d      = '0;
                    line_idx_d  = '0;
                    entry_idx_d = '0;
                    if (bus.GB_LINES != '0) begin
                        state_d = S_GB;
                    end else if (bus.NIT_ENTRIES != '0) begin
                        state_d = S_NIT;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GB: begin
                if (accept_s) begin
                    for (int k = 0; k < GB_WORDS; k++) begin
                        gb_buf_d[k*WORD_WIDTH +: WORD_WIDTH] =
                            (wcnt_q == WCNT_W'(k)) ? bus.s_data
                                                   : gb_buf_q[k*WORD_WIDTH +: WORD_WIDTH];
                    end
                    if (wcnt_q == WCNT_W'(GB_WORDS - 1)) begin
                        wcnt_d     = '0;
                        gb_write_d = 1'b1;
                        gb_data_d  = gb_buf_d;
                        gb_waddr_d = base_q + line_idx_q;   // wraps modulo 2^AW
                        line_idx_d = line_idx_q + AW'(1);
                        // Leave on the same edge that registers the last write.
                        if (line_idx_q == lines_q - AW'(1)) begin
                            state_d = (entries_q != '0) ? S_NIT : S_DONE;
                        end else begin
                            state_d = S_GB;
                        end
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end else begin
                    state_d = S_GB;
                end
            end

            S_NIT: begin
                if (accept_s) begin
                    for (int k = 0; k < NIT_WORDS; k++) begin
                        nit_buf_d[k*WORD_WIDTH +: WORD_WIDTH] =
                            (wcnt_q == WCNT_W'(k)) ? bus.s_data
                                                   : nit_buf_q[k*WORD_WIDTH +: WORD_WIDTH];
                    end
                    if (wcnt_q == WCNT_W'(NIT_WORDS - 1)) begin
                        wcnt_d      = '0;
                        nit_write_d = 1'b1;
                        nit_data_d  = nit_buf_d[NIT_W-1:0];  // top bits of last word dropped
                        nit_addr_d  = entry_idx_q[NW-1:0];
                        entry_idx_d = entry_idx_q + (NW+1)'(1);
                        if (entry_idx_q == entries_q - (NW+1)'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_NIT;
                        end
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end else begin
                    state_d = S_NIT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        s_ready_d   = (state_d == S_GB) || (state_d == S_NIT);
        load_data_d = (state_d != S_IDLE);
        // Completion pulse follows the DONE state so it lands after the last write strobe.
        load_done_d = (state_q == S_DONE);
    end

    // State and output registers; reset abandons any partial line or entry.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            line_idx_q  <= '0;
            entry_idx_q <= '0;
            base_q      <= '0;
            lines_q     <= '0;
            entries_q   <= '0;
            gb_buf_q    <= '0;
            nit_buf_q   <= '0;
            gb_write_q  <= 1'b0;
            gb_waddr_q  <= '0;
            gb_data_q   <= '0;
            nit_write_q <= 1'b0;
            nit_addr_q  <= '0;
            nit_data_q  <= '0;
            s_ready_q   <= 1'b0;
            load_data_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            line_idx_q  <= line_idx_d;
            entry_idx_q <= entry_idx_d;
            base_q      <= base_d;
            lines_q     <= lines_d;
            entries_q   <= entries_d;
            gb_buf_q    <= gb_buf_d;
            nit_buf_q   <= nit_buf_d;
            gb_write_q  <= gb_write_d;
            gb_waddr_q  <= gb_waddr_d;
            gb_data_q   <= gb_data_d;
            nit_write_q <= nit_write_d;
            nit_addr_q  <= nit_addr_d;
            nit_data_q  <= nit_data_d;
            s_ready_q   <= s_ready_d;
            load_data_q <= load_data_d;
            load_done_q <= load_done_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.gb_write  = gb_write_q;
    assign bus.gb_waddr  = gb_waddr_q;
    assign bus.gb_data   = gb_data_q;
    assign bus.nit_write = nit_write_q;
    assign bus.nit_addr  = nit_addr_q;
    assign bus.nit_data  = nit_data_q;
    assign bus.load_data = load_data_q;
    assign bus.load_done = load_done_q;
endmodule

// File: tb/tb_load_streamer.sv
// Directed bench for load_streamer: GB lines, NIT entries with stalls,
// address wrap, empty load, GB->NIT hand-off, mid-load reset, ignored start.
module tb_load_streamer;
    logic clk;
    logic rstn;

    load_streamer_if bus ();

    load_streamer dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_cnt     = 0;
    int start_cyc   = 0;
    int done_cyc    = 0;
    int done_cnt    = 0;
    int ld_bad      = 0;
    bit ready_seen  = 1'b0;

    logic [16:0]  ga[$];
    logic [127:0] gd[$];
    int           gc[$];
    logic [11:0]  na[$];
    logic [329:0] nd[$];
    int           nc[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample everything 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (bus.gb_write) begin
            ga.push_back(bus.gb_waddr);
            gd.push_back(bus.gb_data);
            gc.push_back(cyc_cnt);
            if (!bus.load_data) ld_bad++;
        end
        if (bus.nit_write) begin
            na.push_back(bus.nit_addr);
            nd.push_back(bus.nit_data);
            nc.push_back(cyc_cnt);
        end
        if (bus.load_done) begin
            done_cnt++;
            done_cyc = cyc_cnt;
        end
        if (bus.s_ready) ready_seen = 1'b1;
    endtask

    task automatic clear();
        ga.delete(); gd.delete(); gc.delete();
        na.delete(); nd.delete(); nc.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        ld_bad     = 0;
        ready_seen = 1'b0;
    endtask

    // Pulse start, then scramble the request inputs to prove they were latched.
    task automatic start_load(input logic [16:0] base, input logic [16:0] lines, input logic [12:0] ents);
        bus.GB_BASE_ADDR = base;
        bus.GB_LINES     = lines;
        bus.NIT_ENTRIES  = ents;
        bus.start        = 1'b1;
        start_cyc        = cyc_cnt;
        cyc();
        bus.start        = 1'b0;
        bus.GB_BASE_ADDR = ~base;
        bus.GB_LINES     = lines + 17'd3;
        bus.NIT_ENTRIES  = ents + 13'd7;
    endtask

    task automatic send(input int n, input logic [31:0] first, input bit gappy);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = first + 32'(i);
            cyc();
            if (gappy) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 32'hBAD0_0000 + 32'(i);
                cyc();
            end
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 32'h0;
    endtask

    function automatic logic [329:0] nit_exp(input logic [31:0] first);
        logic [351:0] t;
        for (int k = 0; k < 11; k++) t[32*k +: 32] = first + 32'(k);
        return t[329:0];
    endfunction

    initial begin
        rstn             = 1'b1;
        bus.start        = 1'b0;
        bus.GB_BASE_ADDR = 17'h0;
        bus.GB_LINES     = 17'h0;
        bus.NIT_ENTRIES  = 13'h0;
        bus.s_valid      = 1'b0;
        bus.s_data       = 32'h0;
        repeat (2) cyc();
        chk("rst_s_ready",   bus.s_ready,   1'b0);
        chk("rst_strobes",   {bus.gb_write, bus.nit_write, bus.load_data, bus.load_done}, 4'h0);
        chk("rst_gb",        {bus.gb_waddr, bus.gb_data}, 145'h0);
        chk("rst_nit",       {bus.nit_addr, bus.nit_data}, 342'h0);
        rstn = 1'b0;
        cyc();

        // Two GB lines back to back, no NIT
        clear();
        start_load(17'h100, 17'd2, 13'd0);
        chk("t1_ready", bus.s_ready, 1'b1);
        send(8, 32'h0, 1'b0);
        repeat (3) cyc();
        chk("t1_nwr",    gc.size(), 2);
        chk("t1_addr0",  ga[0], 17'h100);
        chk("t1_data0",  gd[0], {32'd3, 32'd2, 32'd1, 32'd0});
        chk("t1_addr1",  ga[1], 17'h101);
        chk("t1_data1",  gd[1], {32'd7, 32'd6, 32'd5, 32'd4});
        chk("t1_gap",    gc[1] - gc[0], 4);
        chk("t1_donelat", done_cyc - gc[1], 1);
        chk("t1_ndone",  done_cnt, 1);
        chk("t1_ldata",  ld_bad, 0);

        // Two NIT entries with s_valid toggling
        clear();
        start_load(17'h0, 17'd0, 13'd2);
        send(22, 32'hFFFF_F000, 1'b1);
        repeat (3) cyc();
        chk("t2_nwr",   nc.size(), 2);
        chk("t2_ngb",   gc.size(), 0);
        chk("t2_addr0", na[0], 12'h0);
        chk("t2_addr1", na[1], 12'h1);
        chk("t2_data0", nd[0], nit_exp(32'hFFFF_F000));
        chk("t2_data1", nd[1], nit_exp(32'hFFFF_F00B));
        chk("t2_trunc", nd[0][329:320], 10'h00A);
        chk("t2_low",   nd[1][31:0], 32'hFFFF_F00B);
        chk("t2_ndone", done_cnt, 1);

        // Address wrap
        clear();
        start_load(17'h1FFFF, 17'd2, 13'd0);
        send(8, 32'h100, 1'b0);
        repeat (3) cyc();
        chk("t3_nwr",   gc.size(), 2);
        chk("t3_addr0", ga[0], 17'h1FFFF);
        chk("t3_addr1", ga[1], 17'h00000);
        chk("t3_data1", gd[1], {32'h107, 32'h106, 32'h105, 32'h104});

        // Empty load
        clear();
        start_load(17'h55, 17'd0, 13'd0);
        repeat (3) cyc();
        chk("t4_donelat", done_cyc - start_cyc, 2);
        chk("t4_ndone",   done_cnt, 1);
        chk("t4_nowr",    gc.size() + nc.size(), 0);
        chk("t4_noready", ready_seen, 1'b0);

        // GB to NIT hand-off without a bubble
        clear();
        start_load(17'h7, 17'd1, 13'd1);
        send(15, 32'h2000, 1'b0);
        repeat (3) cyc();
        chk("t5_counts", {gc.size(), nc.size()}, {32'd1, 32'd1});
        chk("t5_gbaddr", ga[0], 17'h7);
        chk("t5_gbdata", gd[0], {32'h2003, 32'h2002, 32'h2001, 32'h2000});
        chk("t5_nitdat", nd[0], nit_exp(32'h2004));
        chk("t5_gap",    nc[0] - gc[0], 11);
        chk("t5_donelat", done_cyc - nc[0], 1);

        // Reset after 6 words, then restart
        clear();
        start_load(17'h40, 17'd2, 13'd0);
        send(6, 32'h500, 1'b0);
        chk("t6_prewr", gc.size(), 1);
        rstn = 1'b1;
        #1;
        chk("t6_rst_ctl", {bus.s_ready, bus.gb_write, bus.load_data, bus.load_done}, 4'h0);
        chk("t6_rst_gb",  {bus.gb_waddr, bus.gb_data}, 145'h0);
        clear();
        cyc();
        cyc();
        rstn = 1'b0;
        chk("t6_nopart", gc.size(), 0);
        cyc();
        clear();
        start_load(17'h40, 17'd2, 13'd0);
        send(8, 32'h600, 1'b0);
        repeat (3) cyc();
        chk("t6_nwr",   gc.size(), 2);
        chk("t6_addr0", ga[0], 17'h40);
        chk("t6_data0", gd[0], {32'h603, 32'h602, 32'h601, 32'h600});
        chk("t6_data1", gd[1], {32'h607, 32'h606, 32'h605, 32'h604});

        // Start re-pulsed mid-load
        clear();
        start_load(17'h200, 17'd2, 13'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                bus.start        = 1'b1;
                bus.GB_BASE_ADDR = 17'h300;
                bus.GB_LINES     = 17'd5;
                bus.NIT_ENTRIES  = 13'd3;
            end else begin
                bus.start = 1'b0;
            end
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h700 + 32'(i);
            cyc();
        end
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        repeat (4) cyc();
        chk("t7_nwr",   gc.size(), 2);
        chk("t7_addr0", ga[0], 17'h200);
        chk("t7_addr1", ga[1], 17'h201);
        chk("t7_data1", gd[1], {32'h707, 32'h706, 32'h705, 32'h704});
        chk("t7_nonit", nc.size(), 0);
        chk("t7_ndone", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_streamer.md
LOAD_STREAMER -- requirements
Module: load_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the feature element width in bits.
REQ-002 The block SHALL have parameter length, default 16, meaning the number of elements per global-buffer line; the line is 128 bits.
REQ-003 The block SHALL have parameter NIT_neighbor, default 32, meaning the number of neighbours per NIT entry.
REQ-004 The block SHALL have parameter NIT_point_index, default 10, meaning the index width; the NIT entry is 330 bits.
REQ-005 The block SHALL have parameter global_buf_addr_width, default 17.
REQ-006 The block SHALL have parameter NIT_addr_width, default 12.
REQ-007 The block SHALL have parameter WORD_WIDTH, default 32, meaning the input stream word width.
REQ-008 The port list SHALL be, in order:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-high reset; the codebase name is kept, but the polarity is high.
- start  in  1  single-cycle load request.
- GB_BASE_ADDR  in  global_buf_addr_width  first global-buffer line address.
- GB_LINES  in  global_buf_addr_width  number of 128-bit lines to load.
- NIT_ENTRIES  in  NIT_addr_width+1  number of NIT entries to load.
- s_valid  in  1  stream word valid.
- s_data  in  WORD_WIDTH  stream word.
- s_ready  out  1  stream word accepted when s_valid&s_ready.
- gb_write  out  1  global-buffer write strobe.
- gb_waddr  out  global_buf_addr_width  global-buffer write address.
- gb_data  out  DATA_WIDTH*length  global-buffer write line.
- nit_write  out  1  NIT write strobe.
- nit_addr  out  NIT_addr_width  NIT write address.
- nit_data  out  (NIT_neighbor+1)*NIT_point_index  NIT entry.
- load_data  out  1  high while loading; feeds the top-level load mux.
- load_done  out  1  one-cycle completion pulse; feeds LOAD_DONE.

Function
REQ-009 The FSM SHALL have the states IDLE, GB_LOAD, NIT_LOAD and DONE.
REQ-010 IDLE SHALL transition on start as follows:
- GB_LINES!=0 -> GB_LOAD.
- GB_LINES==0 and NIT_ENTRIES!=0 -> NIT_LOAD.
- both counts 0 -> DONE.
REQ-011 GB_BASE_ADDR, GB_LINES and NIT_ENTRIES SHALL be captured on the start cycle; later changes to them SHALL be ignored until the next load.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 s_ready SHALL equal 1 in GB_LOAD and NIT_LOAD, and 0 in IDLE and DONE; words presented while s_ready=0 SHALL NOT be consumed.
REQ-014 GB packing SHALL work as follows:
- 4 accepted words form one line.
- The first word goes to bits[31:0], the fourth to bits[127:96].
- A word counter (0..3) advances only on accepted words.
REQ-015 On acceptance of the 4th word of a line, the next cycle SHALL present gb_write=1 for exactly one cycle, with gb_data the packed line and gb_waddr = GB_BASE_ADDR + line index.
REQ-016 Address arithmetic SHALL be modulo 2^global_buf_addr_width and wrap silently.
REQ-017 After the GB_LINES-th line is accepted, the FSM SHALL move to NIT_LOAD if NIT_ENTRIES!=0, otherwise to DONE.
REQ-018 That transition SHALL occur in the same edge as the final write being registered, leaving no stall cycle.
REQ-019 NIT packing SHALL work as follows:
- 11 accepted words form one entry.
- Word k goes to bits[32k+31:32k].
- Bits above 329 of word 10 are discarded.
REQ-020 On acceptance of the 11th word of an entry, the next cycle SHALL present nit_write=1 for one cycle, with nit_addr = entry index starting at 0 and nit_data the entry.
REQ-021 After NIT_ENTRIES entries, the FSM SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle with load_done=1, then return to IDLE.
REQ-023 load_data SHALL be 1 from the cycle after start through the DONE cycle inclusive, so that it covers the final write strobe.
REQ-024 gb_data, gb_waddr, nit_data and nit_addr SHALL hold their last values when the strobes are low.
REQ-025 Any stall gaps in s_valid SHALL NOT corrupt partial packing.
REQ-026 Throughput SHALL be one word per cycle with no bubbles between lines, entries or phases.

Reset
REQ-027 The following SHALL be cleared asynchronously on rstn=1:
- state=IDLE.
- All counters=0.
- s_ready, gb_write, nit_write, load_data, load_done = 0.
- gb_waddr, gb_data, nit_addr, nit_data = 0.
REQ-028 Reset mid-load SHALL abandon the partial line or entry with no write strobe, and the next start SHALL begin from word 0.

Verification
REQ-029 The bench SHALL cover GB_BASE_ADDR=0x100, GB_LINES=2, NIT_ENTRIES=0, 8 back-to-back words 0..7 -> required response:
- gb_write at 0x100 with data {3,2,1,0}.
- gb_write at 0x101 with data {7,6,5,4}.
- load_done one cycle after the 2nd write cycle.
REQ-030 The bench SHALL cover GB_LINES=0, NIT_ENTRIES=2, 22 words with s_valid toggling every other cycle -> required response: nit_write at addr 0 and then addr 1, each with the correct 330-bit packing and word 10 truncated.
REQ-031 The bench SHALL cover GB_BASE_ADDR=0x1FFFF, GB_LINES=2 -> required response: writes at 0x1FFFF then 0x00000.
REQ-032 The bench SHALL cover both counts 0 -> required response: load_done pulses 2 cycles after start, with no write strobes and s_ready never 1.
REQ-033 The bench SHALL cover rstn asserted after 6 words of a GB_LINES=2 load, then a restart -> required response:
- Outputs are zero immediately.
- There is no gb_write for the partial line.
- The restart re-packs from word 0.
REQ-034 The bench SHALL cover start pulsed again during GB_LOAD -> required response: it is ignored; counts and addresses are unchanged and the load completes normally.
